// File: rtl/golden_nonce_queue.sv
// Golden-nonce FIFO between the hashing control unit and the communication block.
// Applies a latency correction, drops consecutive duplicates and counts overflow drops.
module golden_nonce_queue #(
   parameter int unsigned DEPTH        = 8,
   parameter logic [31:0] NONCE_OFFSET = 32'd0
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       flush,
   input  logic                       in_valid,
   input  logic [31:0]                in_nonce,
   output logic                       out_valid,
   output logic [31:0]                out_nonce,
   input  logic                       out_ack,
   output logic [$clog2(DEPTH):0]     count,
   output logic [15:0]                overflow_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] cnt;
   logic [31:0]   last_nonce;
   logic          last_vld;
   logic [15:0]   ovf;

   logic [31:0]   corrected;
   logic          dup;
   logic          full;
   logic          pop;
   logic          push;
   logic          drop;

   always_comb begin
      corrected = in_nonce - NONCE_OFFSET;
      dup       = in_valid && last_vld && (corrected == last_nonce);
      full      = (cnt == CW'(DEPTH));
      pop       = out_ack && (cnt != '0);
      // A pop in the same cycle frees the slot, so a full queue still accepts.
      push      = in_valid && !dup && (!full || pop);
      drop      = in_valid && !dup && full && !pop;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         cnt        <= '0;
         last_nonce <= '0;
         last_vld   <= 1'b0;
         ovf        <= '0;
      end else if (flush) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         cnt      <= '0;
         last_vld <= 1'b0;
      end else begin
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         if (push) begin
            mem[wr_ptr] <= corrected;
            wr_ptr      <= wr_ptr + AW'(1);
            last_nonce  <= corrected;
            last_vld    <= 1'b1;
         end
         if (drop && (ovf != '1)) ovf <= ovf + 16'd1;
         case ({push, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   assign out_valid      = (cnt != '0);
   assign out_nonce      = mem[rd_ptr];
   assign count          = cnt;
   assign overflow_count = ovf;

endmodule

// File: tb/tb_golden_nonce_queue.sv
// Scoreboard bench for golden_nonce_queue (DEPTH=8, NONCE_OFFSET=253).
module tb_golden_nonce_queue;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_nonce;
   logic        out_valid;
   logic [31:0] out_nonce;
   logic        out_ack;
   logic [3:0]  count;
   logic [15:0] overflow_count;

   int errors = 0;
   int checks = 0;
   logic [31:0] expq [$];

   golden_nonce_queue #(.DEPTH(8), .NONCE_OFFSET(32'd253)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_nonce(in_nonce),
      .out_valid(out_valid), .out_nonce(out_nonce), .out_ack(out_ack),
      .count(count), .overflow_count(overflow_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // present a push for one cycle; exp_store says whether the scoreboard expects it stored
   task automatic push(input logic [31:0] n, input logic [31:0] exp_val, input bit exp_store);
      in_valid = 1'b1;
      in_nonce = n;
      if (exp_store) expq.push_back(exp_val);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic acks(input int n);
      out_ack = 1'b1;
      repeat (n) tick();
      out_ack = 1'b0;
   endtask

   // monitor: every accepted pop is compared with the scoreboard head
   always @(negedge clk) begin
      if (reset_n && !flush && out_valid && out_ack) begin
         checks++;
         if (expq.size() == 0) begin
            errors++;
            $display("FAIL pop_unexpected: got %h expected no entry", out_nonce);
         end else begin
            logic [31:0] e;
            e = expq.pop_front();
            if (out_nonce !== e) begin
               errors++;
               $display("FAIL pop_data: got %h expected %h", out_nonce, e);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_nonce = '0; out_ack = 1'b0;
      repeat (3) tick();
      check("reset_valid", 32'(out_valid), 32'd0);
      check("reset_count", 32'(count), 32'd0);
      check("reset_ovf", 32'(overflow_count), 32'd0);
      check("reset_nonce", out_nonce, 32'd0);
      reset_n = 1'b1;
      tick();

      // single push: 0x105 - 253 = 8
      push(32'h0000_0105, 32'h0000_0008, 1'b1);
      check("single_valid", 32'(out_valid), 32'd1);
      check("single_nonce", out_nonce, 32'h0000_0008);
      check("single_count", 32'(count), 32'd1);
      acks(1);
      check("single_pop_valid", 32'(out_valid), 32'd0);
      check("single_pop_count", 32'(count), 32'd0);

      // offset wrap: 10 - 253
      push(32'd10, 32'hFFFF_FF0D, 1'b1);
      check("wrap_nonce", out_nonce, 32'hFFFF_FF0D);
      acks(1);

      // empty with simultaneous push and ack: ack ignored
      out_ack = 1'b1;
      push(32'h0000_0500, 32'h0000_0403, 1'b1);
      out_ack = 1'b0;
      check("empty_pushack_count", 32'(count), 32'd1);
      acks(1);

      // fill + overflow: 0x1000+i - 253 = 0xF03+i, last two dropped
      for (int i = 0; i < 10; i++)
         push(32'h0000_1000 + 32'(i), 32'h0000_0F03 + 32'(i), (i < 8));
      check("full_count", 32'(count), 32'd8);
      check("full_ovf", 32'(overflow_count), 32'd2);

      // full with push and ack together
      out_ack = 1'b1;
      push(32'h0000_2000, 32'h0000_1F03, 1'b1);
      out_ack = 1'b0;
      check("full_pushack_count", 32'(count), 32'd8);
      check("full_pushack_ovf", 32'(overflow_count), 32'd2);
      acks(8);
      check("drain_valid", 32'(out_valid), 32'd0);
      check("drain_count", 32'(count), 32'd0);
      check("drain_sb_empty", 32'(expq.size()), 32'd0);

      // duplicates: 5,5,6,5 -> three stored
      push(32'd5, 32'hFFFF_FF08, 1'b1);
      push(32'd5, 32'hFFFF_FF08, 1'b0);
      push(32'd6, 32'hFFFF_FF09, 1'b1);
      push(32'd5, 32'hFFFF_FF08, 1'b1);
      check("dup_count", 32'(count), 32'd3);

      // flush with in_valid and out_ack in the same cycle
      flush = 1'b1; in_valid = 1'b1; in_nonce = 32'd7; out_ack = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0; out_ack = 1'b0;
      expq.delete();
      check("flush_count", 32'(count), 32'd0);
      check("flush_valid", 32'(out_valid), 32'd0);
      check("flush_ovf", 32'(overflow_count), 32'd2);
      push(32'd5, 32'hFFFF_FF08, 1'b1);
      check("post_flush_count", 32'(count), 32'd1);
      acks(1);

      // build count=4, overflow=3 then async reset between edges
      for (int i = 0; i < 9; i++)
         push(32'h0000_3000 + 32'(i), 32'h0000_2F03 + 32'(i), (i < 8));
      check("pre_rst_ovf", 32'(overflow_count), 32'd3);
      acks(4);
      check("pre_rst_count", 32'(count), 32'd4);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_valid", 32'(out_valid), 32'd0);
      check("async_count", 32'(count), 32'd0);
      check("async_ovf", 32'(overflow_count), 32'd0);
      check("async_nonce", out_nonce, 32'd0);
      expq.delete();
      tick();
      reset_n = 1'b1;
      tick();
      check("post_rst_valid", 32'(out_valid), 32'd0);
      push(32'h0000_0042, 32'hFFFF_FF45, 1'b1);
      check("post_rst_nonce", out_nonce, 32'hFFFF_FF45);
      acks(1);
      check("final_sb_empty", 32'(expq.size()), 32'd0);
      check("final_valid", 32'(out_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
